ram_block_copy: RTL and testbench



---
 rtl/ram_block_copy_pkg.sv | 13 +
 rtl/ram_block_copy.sv | 100 ++++++++++
 tb/tb_ram_block_copy.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_block_copy_pkg.sv
// ram_block_copy_pkg: shared widths and FSM encoding for the RAM block-copy master.
package ram_block_copy_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_LEN_W  = DEF_ADDR_W + 1;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/ram_block_copy.sv
// ram_block_copy: copies LEN words SRC->DST inside a single-port RAM, one word per READ/CAPT/WRITE triple.
module ram_block_copy
  import ram_block_copy_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  count,
  output logic              m_cen,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, addr_q;
  logic [LEN_W-1:0] rem_q, rem_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d, dout_q;
  logic busy_q, done_q, cen_q, wen_q, rd_d, wr_d;
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    buf_d = buf_q;
    case (state_q)
      ST_IDLE: if (start) begin
        cnt_d = '0;
        if (length != '0) begin
          src_d = src_addr;
          dst_d = dst_addr;
          rem_d = length;
          state_d = ST_READ;
        end else state_d = ST_DONE;
      end
      ST_READ: state_d = ST_CAPT;
      ST_CAPT: begin
        buf_d = m_din;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        src_d = src_q + 1'b1;
        dst_d = dst_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
        rem_d = rem_q - 1'b1;
        state_d = (rem_q > LEN_W'(1)) ? ST_READ : ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // Outputs are registered from the next state, so the bus reflects the state it is in.
  assign rd_d = (state_d == ST_READ);
  assign wr_d = (state_d == ST_WRITE);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      buf_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cen_q <= 1'b0;
      wen_q <= 1'b0;
      addr_q <= '0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
      busy_q <= (state_d != ST_IDLE);
      done_q <= (state_d == ST_DONE);
      cen_q <= rd_d | wr_d;
      wen_q <= wr_d;
      addr_q <= rd_d ? src_d : wr_d ? dst_d : '0;
      dout_q <= wr_d ? buf_d : '0;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign count = cnt_q;
  assign m_cen = cen_q;
  assign m_wen = wen_q;
  assign m_addr = addr_q;
  assign m_dout = dout_q;
endmodule

// File: tb/tb_ram_block_copy.sv
// tb_ram_block_copy: random and directed block copies checked against a forward-copy array model.
module tb_ram_block_copy;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, load = 1'b0;
  logic busy, done, m_cen, m_wen;
  logic [7:0] src_addr = '0, dst_addr = '0, m_addr;
  logic [8:0] length = '0, count;
  logic [63:0] m_dout, s_dout;
  logic [63:0] mem [256];
  logic [63:0] img [256];
  logic [63:0] ref_mem [256];
  logic [7:0] alog [$];
  logic [7:0] aexp [$];
  int errors = 0, checks = 0;
  int lat, ndone;
  logic busy_after;

  always #5 clk = ~clk;

  ram_block_copy dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .busy(busy), .done(done), .count(count), .m_cen(m_cen), .m_wen(m_wen),
    .m_addr(m_addr), .m_dout(m_dout), .m_din(s_dout)
  );

  // Behavioural single-port RAM: registered read, write or idle zeroes s_dout.
  always @(posedge clk) begin
    if (load) for (int i = 0; i < 256; i++) mem[i] <= img[i];
    else if (m_cen && m_wen) mem[m_addr] <= m_dout;
    s_dout <= (m_cen && !m_wen) ? mem[m_addr] : '0;
  end

  task automatic fill_random();
    for (int i = 0; i < 256; i++) img[i] = {$urandom, $urandom};
  endtask

  task automatic load_img();
    for (int i = 0; i < 256; i++) ref_mem[i] = img[i];
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic model_copy(input int s, input int d, input int n);
    for (int i = 0; i < n; i++) ref_mem[(d + i) % 256] = ref_mem[(s + i) % 256];
  endtask

  function automatic int mem_diffs();
    int c = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) c++;
    return c;
  endfunction

  task automatic run_copy(input int s, input int d, input int n, input int inj_at,
                          input int is, input int id, input int il);
    logic [7:0] s8 = s[7:0], d8 = d[7:0], is8 = is[7:0], id8 = id[7:0];
    logic [8:0] n9 = n[8:0], il9 = il[8:0];
    alog.delete();
    lat = -1;
    ndone = 0;
    busy_after = 1'b1;
    @(negedge clk);
    src_addr = s8; dst_addr = d8; length = n9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 900; cyc++) begin
      if (m_cen) alog.push_back(m_addr);
      if (done) begin
        ndone++;
        if (lat < 0) lat = cyc;
      end else if (lat >= 0) begin
        if (cyc == lat + 1) busy_after = busy;
        if (!busy) break;
      end
      if (cyc == inj_at) begin
        src_addr = is8; dst_addr = id8; length = il9; start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, m_cen, m_wen} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, m_cen, m_wen});
    end
    checks++;
    if (m_addr !== 8'd0 || m_dout !== 64'd0 || count !== 9'd0) begin
      errors++; $display("FAIL reset_bus: addr=%0d dout=%h count=%0d expected all 0", m_addr, m_dout, count);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_basic();
    fill_random();
    img[0] = 64'h11; img[1] = 64'h22; img[2] = 64'h33; img[3] = 64'h44;
    load_img();
    model_copy(0, 16, 4);
    run_copy(0, 16, 4, -1, 0, 0, 0);
    checks++;
    if (lat !== 13) begin errors++; $display("FAIL basic_latency: got %0d expected 13", lat); end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", ndone); end
    checks++;
    if (count !== 9'd4) begin errors++; $display("FAIL basic_count: got %0d expected 4", count); end
    checks++;
    if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after_done: got %b expected 0", busy_after); end
    checks++;
    if (mem[16] !== 64'h11 || mem[17] !== 64'h22 || mem[18] !== 64'h33 || mem[19] !== 64'h44) begin
      errors++; $display("FAIL basic_dst: got %h %h %h %h expected 11 22 33 44", mem[16], mem[17], mem[18], mem[19]);
    end
    checks++;
    if (mem_diffs() != 0) begin errors++; $display("FAIL basic_mem: %0d words differ, expected 0", mem_diffs()); end
  endtask

  task automatic test_zero_len();
    fill_random();
    load_img();
    run_copy(5, 9, 0, -1, 0, 0, 0);
    checks++;
    if (alog.size() != 0) begin errors++; $display("FAIL zero_cen: got %0d accesses expected 0", alog.size()); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", lat); end
    checks++;
    if (count !== 9'd0) begin errors++; $display("FAIL zero_count: got %0d expected 0", count); end
    checks++;
    if (mem_diffs() != 0) begin errors++; $display("FAIL zero_mem: %0d words differ, expected 0", mem_diffs()); end
  endtask

  task automatic test_wrap();
    int ok = 1;
    fill_random();
    img[254] = 64'hAA; img[255] = 64'hBB; img[0] = 64'hCC;
    load_img();
    model_copy(254, 100, 3);
    aexp.delete();
    for (int i = 0; i < 3; i++) begin
      aexp.push_back(8'((254 + i) % 256));
      aexp.push_back(8'(100 + i));
    end
    run_copy(254, 100, 3, -1, 0, 0, 0);
    if (alog.size() != aexp.size()) ok = 0;
    else for (int i = 0; i < aexp.size(); i++) if (alog[i] !== aexp[i]) ok = 0;
    checks++;
    if (ok == 0) begin errors++; $display("FAIL wrap_addr_seq: got %p expected %p", alog, aexp); end
    checks++;
    if (mem[100] !== 64'hAA || mem[101] !== 64'hBB || mem[102] !== 64'hCC) begin
      errors++; $display("FAIL wrap_dst: got %h %h %h expected aa bb cc", mem[100], mem[101], mem[102]);
    end
    checks++;
    if (mem_diffs() != 0) begin errors++; $display("FAIL wrap_mem: %0d words differ, expected 0", mem_diffs()); end
  endtask

  task automatic test_overlap();
    fill_random();
    img[0] = 64'd1; img[1] = 64'd2;
    load_img();
    model_copy(0, 1, 2);
    run_copy(0, 1, 2, -1, 0, 0, 0);
    checks++;
    if (mem[1] !== 64'd1 || mem[2] !== 64'd1) begin
      errors++; $display("FAIL overlap_dst: got %h %h expected 1 1", mem[1], mem[2]);
    end
    checks++;
    if (mem_diffs() != 0) begin errors++; $display("FAIL overlap_mem: %0d words differ, expected 0", mem_diffs()); end
  endtask

  task automatic test_ignore_start();
    fill_random();
    load_img();
    model_copy(10, 50, 5);
    run_copy(10, 50, 5, 4, 60, 120, 3);
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL ignore_done_pulses: got %0d expected 1", ndone); end
    checks++;
    if (count !== 9'd5) begin errors++; $display("FAIL ignore_count: got %0d expected 5", count); end
    checks++;
    if (mem_diffs() != 0) begin errors++; $display("FAIL ignore_mem: %0d words differ, expected 0", mem_diffs()); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d2 = 8'd71;
    int k = 0;
    fill_random();
    load_img();
    model_copy(20, 70, 1);
    @(negedge clk);
    src_addr = 8'd20; dst_addr = 8'd70; length = 9'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (k < 50 && !(m_cen && m_wen && m_addr == d2)) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 50) begin errors++; $display("FAIL midreset_wait: word 2 write not seen within %0d cycles", k); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, m_cen, m_wen} !== 4'b0 || m_addr !== 8'd0 || m_dout !== 64'd0 || count !== 9'd0) begin
      errors++; $display("FAIL midreset_outputs: busy=%b done=%b cen=%b wen=%b addr=%0d dout=%h count=%0d expected all 0",
                         busy, done, m_cen, m_wen, m_addr, m_dout, count);
    end
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_diffs() != 0) begin errors++; $display("FAIL midreset_mem: %0d words differ, expected 0", mem_diffs()); end
    model_copy(30, 80, 4);
    run_copy(30, 80, 4, -1, 0, 0, 0);
    checks++;
    if (lat !== 13 || count !== 9'd4) begin
      errors++; $display("FAIL midreset_recover: latency=%0d count=%0d expected 13 4", lat, count);
    end
    checks++;
    if (mem_diffs() != 0) begin errors++; $display("FAIL midreset_recover_mem: %0d words differ, expected 0", mem_diffs()); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 9; t++) begin
      int s = $urandom_range(0, 255), d = $urandom_range(0, 255);
      int n = (t == 8) ? 256 : $urandom_range(1, 20);
      fill_random();
      load_img();
      model_copy(s, d, n);
      run_copy(s, d, n, -1, 0, 0, 0);
      checks++;
      if (lat !== 3 * n + 1 || count !== 9'(n)) begin
        errors++; $display("FAIL rand_timing[%0d]: latency=%0d count=%0d expected %0d %0d", t, lat, count, 3 * n + 1, n);
      end
      checks++;
      if (mem_diffs() != 0) begin
        errors++; $display("FAIL rand_mem[%0d] s=%0d d=%0d n=%0d: %0d words differ, expected 0", t, s, d, n, mem_diffs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_overlap();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
